// File: rtl/decode_stage_pipe_pkg.sv
// Shared definitions for the RV32 decode stage: opcode, ALU, load/store type
// and func7 encodings, zero constants, the decoded control bundle, and the
// immediate generator.
package decode_stage_pipe_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] LT_B  = 3'b000;
  localparam logic [2:0] LT_H  = 3'b001;
  localparam logic [2:0] LT_W  = 3'b010;
  localparam logic [2:0] LT_BU = 3'b100;
  localparam logic [2:0] LT_HU = 3'b101;

  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_W = 2'b10;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] ZERO_32 = 32'd0;
  localparam logic [2:0]  ZERO_3  = 3'd0;

  typedef struct packed {
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       wb_reg_file;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic       rs1_used;
    logic       rs2_used;
    logic       illegal;
  } ctrl_t;

  // 32-bit sign-extended immediate; U-type already shifted into [31:12].
  function automatic logic [31:0] imm_gen(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {ins[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm = ZERO_32;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// IF/ID -> ID -> ID/EX handshake bundle.
//  Upstream : in_valid, in_ready, instruction_in, pc_in
//  Downstream: ex_ready, out_valid and all registered out_* fields
// Modport slave is the decode stage; modport master is its environment.
interface decode_stage_pipe_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instruction_in;
  logic [XLEN-1:0]       pc_in;
  logic                  ex_ready;
  logic                  out_valid;
  logic [XLEN-1:0]       out_pc;
  logic [XLEN-1:0]       out_op1;
  logic [XLEN-1:0]       out_op2;
  logic [XLEN-1:0]       out_imm;
  logic [REG_ADDR_W-1:0] out_rs1;
  logic [REG_ADDR_W-1:0] out_rs2;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [6:0]            out_opcode;
  logic [2:0]            out_func3;
  logic [6:0]            out_func7;
  logic                  out_alu_src;
  logic                  out_mem_write;
  logic                  out_mem_read;
  logic                  out_wb_reg_file;
  logic [2:0]            out_mem_load_type;
  logic [1:0]            out_mem_store_type;
  logic                  out_invalid;

  modport slave (
    input  in_valid, instruction_in, pc_in, ex_ready,
    output in_ready, out_valid, out_pc, out_op1, out_op2, out_imm,
           out_rs1, out_rs2, out_rd, out_opcode, out_func3, out_func7,
           out_alu_src, out_mem_write, out_mem_read, out_wb_reg_file,
           out_mem_load_type, out_mem_store_type, out_invalid
  );

  modport master (
    output in_valid, instruction_in, pc_in, ex_ready,
    input  in_ready, out_valid, out_pc, out_op1, out_op2, out_imm,
           out_rs1, out_rs2, out_rd, out_opcode, out_func3, out_func7,
           out_alu_src, out_mem_write, out_mem_read, out_wb_reg_file,
           out_mem_load_type, out_mem_store_type, out_invalid
  );
endinterface

// File: rtl/decode_stage_pipe_ctrl.sv
// decode_controller: combinational control-bit decode from opcode/func3/func7.
//  Inputs : opcode, func3, func7
//  Output : ctrl (alu_src, mem/wb controls, load/store type, rs usage, illegal)
// Illegal encodings clear mem_write, mem_read and wb_reg_file.
module decode_controller
  import decode_stage_pipe_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output ctrl_t      ctrl
);

  logic legal;

  always_comb begin
    ctrl          = '0;
    ctrl.rs1_used = 1'b1;
    legal         = 1'b1;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        ctrl.rs1_used    = 1'b0;
        ctrl.alu_src     = 1'b1;
        ctrl.wb_reg_file = 1'b1;
      end
      OPC_JALR: begin
        ctrl.alu_src     = 1'b1;
        ctrl.wb_reg_file = 1'b1;
        legal            = (func3 == ZERO_3);
      end
      OPC_BRANCH: begin
        ctrl.rs2_used = 1'b1;
        legal         = (func3 != 3'b010) && (func3 != 3'b011);
      end
      OPC_LOAD: begin
        ctrl.alu_src     = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.wb_reg_file = 1'b1;
        ctrl.load_type   = func3;
        legal = (func3 == LT_B) || (func3 == LT_H) || (func3 == LT_W) ||
                (func3 == LT_BU) || (func3 == LT_HU);
      end
      OPC_STORE: begin
        ctrl.rs2_used   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.store_type = func3[1:0];
        legal = (func3[2] == 1'b0) && (func3[1:0] != 2'b11);
      end
      OPC_OP_IMM: begin
        ctrl.alu_src     = 1'b1;
        ctrl.wb_reg_file = 1'b1;
        // Only the shift forms carry a func7 field.
        if (func3 == 3'b001)      legal = (func7 == F7_ZERO);
        else if (func3 == 3'b101) legal = (func7 == F7_ZERO) || (func7 == F7_ALT);
      end
      OPC_OP: begin
        ctrl.rs2_used    = 1'b1;
        ctrl.wb_reg_file = 1'b1;
        legal = (func7 == F7_ZERO) ||
                ((func7 == F7_ALT) && ((func3 == 3'b000) || (func3 == 3'b101)));
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl.illegal     = 1'b1;
      ctrl.mem_write   = 1'b0;
      ctrl.mem_read    = 1'b0;
      ctrl.wb_reg_file = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage_pipe_regfile.sv
// regfile_bypass: architectural register file, two combinational read ports,
// one synchronous write port. x0 reads 0 and ignores writes. With BYPASS_EN=1
// a read of the address being written this cycle returns the new data.
//  clk, rst            : clock, synchronous active-high reset (clears all)
//  wr_en/wr_addr/wr_data: WB write port
//  rd_addr_a/b, rd_data_a/b: read ports
module regfile_bypass #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [XLEN-1:0]       rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [XLEN-1:0]       rd_data_b
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic            wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != '0) begin
      if (BYPASS_EN && wr_live && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      else                                                 rd_data_a = regs_q[rd_addr_a];
    end
    if (rd_addr_b != '0) begin
      if (BYPASS_EN && wr_live && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
      else                                                 rd_data_b = regs_q[rd_addr_b];
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RV32 ID stage with a registered ID/EX entry.
//  clk, rst         : clock, synchronous active-high reset
//  bus (slave)      : IF/ID handshake in, ID/EX handshake and fields out
//  id_flush         : kill ID and ID/EX contents
//  reg_file_wr_*    : WB write port into the register file
//  cnt_decoded      : saturating count of entries taken by EX
//  cnt_bubbles      : saturating count of load-use bubbles
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit BYPASS_EN  = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  decode_stage_pipe_if.slave    bus,
  input  logic                  id_flush,
  input  logic                  reg_file_wr_en,
  input  logic [REG_ADDR_W-1:0] reg_file_wr_addr,
  input  logic [XLEN-1:0]       reg_file_wr_data,
  output logic [CNT_W-1:0]      cnt_decoded,
  output logic [CNT_W-1:0]      cnt_bubbles
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       op1;
    logic [XLEN-1:0]       op2;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic                  alu_src;
    logic                  mem_write;
    logic                  mem_read;
    logic                  wb_reg_file;
    logic [2:0]            load_type;
    logic [1:0]            store_type;
    logic                  invalid;
  } idex_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [31:0]           ins;
  ctrl_t                 ctrl;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0]       rf_a, rf_b;
  idex_t                 dec;
  idex_t                 idex_q, idex_d;
  logic                  vld_q, vld_d;
  logic [CNT_W-1:0]      cnt_dec_q, cnt_dec_d, cnt_bub_q, cnt_bub_d;
  logic                  advance, hz, bubble;

  assign ins = bus.instruction_in;

  decode_controller u_ctrl (
    .opcode (ins[6:0]),
    .func3  (ins[14:12]),
    .func7  (ins[31:25]),
    .ctrl   (ctrl)
  );

  // Unused source fields read as x0 so they neither fetch data nor hazard.
  assign rs1_addr = ctrl.rs1_used ? ins[15 +: REG_ADDR_W] : '0;
  assign rs2_addr = ctrl.rs2_used ? ins[20 +: REG_ADDR_W] : '0;

  regfile_bypass #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W),
    .BYPASS_EN  (BYPASS_EN)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (reg_file_wr_en),
    .wr_addr   (reg_file_wr_addr),
    .wr_data   (reg_file_wr_data),
    .rd_addr_a (rs1_addr),
    .rd_data_a (rf_a),
    .rd_addr_b (rs2_addr),
    .rd_data_b (rf_b)
  );

  always_comb begin
    dec             = '0;
    dec.pc          = bus.pc_in;
    dec.op1         = rf_a;
    dec.op2         = rf_b;
    dec.imm         = XLEN'($signed(imm_gen(ins)));
    dec.rs1         = rs1_addr;
    dec.rs2         = rs2_addr;
    dec.rd          = ins[7 +: REG_ADDR_W];
    dec.opcode      = ins[6:0];
    dec.func3       = ins[14:12];
    dec.func7       = ins[31:25];
    dec.alu_src     = ctrl.alu_src;
    dec.mem_write   = ctrl.mem_write;
    dec.mem_read    = ctrl.mem_read;
    dec.wb_reg_file = ctrl.wb_reg_file;
    dec.load_type   = ctrl.load_type;
    dec.store_type  = ctrl.store_type;
    dec.invalid     = ctrl.illegal;
  end

  assign advance = !vld_q || bus.ex_ready;
  // Load in ID/EX whose destination is a source of the instruction in ID.
  assign hz = vld_q && idex_q.mem_read && (idex_q.rd != '0) &&
              ((rs1_addr == idex_q.rd) || (rs2_addr == idex_q.rd));
  assign bus.in_ready = (advance && !hz) || id_flush;

  always_comb begin
    idex_d    = idex_q;
    vld_d     = vld_q;
    bubble    = 1'b0;
    if (id_flush) begin
      vld_d = 1'b0;
    end else if (advance) begin
      if (hz && bus.in_valid) begin
        vld_d  = 1'b0;
        bubble = 1'b1;
      end else if (bus.in_valid && bus.in_ready) begin
        idex_d = dec;
        vld_d  = 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end
    cnt_dec_d = (vld_q && bus.ex_ready) ? sat_inc(cnt_dec_q) : cnt_dec_q;
    cnt_bub_d = bubble ? sat_inc(cnt_bub_q) : cnt_bub_q;
  end

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= '0;
      vld_q     <= 1'b0;
      cnt_dec_q <= '0;
      cnt_bub_q <= '0;
    end else begin
      idex_q    <= idex_d;
      vld_q     <= vld_d;
      cnt_dec_q <= cnt_dec_d;
      cnt_bub_q <= cnt_bub_d;
    end
  end

  assign bus.out_valid          = vld_q;
  assign bus.out_pc             = idex_q.pc;
  assign bus.out_op1            = idex_q.op1;
  assign bus.out_op2            = idex_q.op2;
  assign bus.out_imm            = idex_q.imm;
  assign bus.out_rs1            = idex_q.rs1;
  assign bus.out_rs2            = idex_q.rs2;
  assign bus.out_rd             = idex_q.rd;
  assign bus.out_opcode         = idex_q.opcode;
  assign bus.out_func3          = idex_q.func3;
  assign bus.out_func7          = idex_q.func7;
  assign bus.out_alu_src        = idex_q.alu_src;
  assign bus.out_mem_write      = idex_q.mem_write;
  assign bus.out_mem_read       = idex_q.mem_read;
  assign bus.out_wb_reg_file    = idex_q.wb_reg_file;
  assign bus.out_mem_load_type  = idex_q.load_type;
  assign bus.out_mem_store_type = idex_q.store_type;
  assign bus.out_invalid        = idex_q.invalid;
  assign cnt_decoded            = cnt_dec_q;
  assign cnt_bubbles            = cnt_bub_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        ex_ready = 1'b1;
  logic        id_flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [15:0] cnt_dec_a, cnt_bub_a;
  logic [1:0]  cnt_dec_b, cnt_bub_b;

  int n_tot = 0;
  int n_bad = 0;
  int n_iss = 0;
  int last_wait = 0;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.XLEN(32), .REG_ADDR_W(5)) ifa ();
  decode_stage_pipe_if #(.XLEN(32), .REG_ADDR_W(5)) ifb ();

  assign ifa.in_valid = in_valid;
  assign ifa.instruction_in = instr;
  assign ifa.pc_in = pc;
  assign ifa.ex_ready = ex_ready;
  assign ifb.in_valid = in_valid;
  assign ifb.instruction_in = instr;
  assign ifb.pc_in = pc;
  assign ifb.ex_ready = ex_ready;

  decode_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .BYPASS_EN(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .id_flush(id_flush),
    .reg_file_wr_en(wr_en), .reg_file_wr_addr(wr_addr), .reg_file_wr_data(wr_data),
    .cnt_decoded(cnt_dec_a), .cnt_bubbles(cnt_bub_a));

  decode_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .BYPASS_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .id_flush(id_flush),
    .reg_file_wr_en(wr_en), .reg_file_wr_addr(wr_addr), .reg_file_wr_data(wr_data),
    .cnt_decoded(cnt_dec_b), .cnt_bubbles(cnt_bub_b));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference register file, written by the bench's own WB stimulus.
  logic [31:0] mrf [32] = '{default: 32'd0};
  always @(posedge clk) if (wr_en && wr_addr != 5'd0) mrf[wr_addr] <= wr_data;

  function automatic logic [31:0] rdm(input logic [4:0] a, input logic byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return mrf[a];
  endfunction

  typedef struct {
    logic [31:0] pc, op1, op1b, op2, imm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic        inv, mr, mw, wb;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ex_ready) begin
      if (sb.size() == 0) check("sb_empty", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("pc",    ifa.out_pc, e.pc);
        check("op1",   ifa.out_op1, e.op1);
        check("op2",   ifa.out_op2, e.op2);
        check("imm",   ifa.out_imm, e.imm);
        check("rd",    ifa.out_rd, e.rd);
        check("opc",   ifa.out_opcode, e.opc);
        check("inv",   ifa.out_invalid, e.inv);
        check("mrd",   ifa.out_mem_read, e.mr);
        check("mwr",   ifa.out_mem_write, e.mw);
        check("wb",    ifa.out_wb_reg_file, e.wb);
        check("b_vld", ifb.out_valid, 1'b1);
        check("b_op1", ifb.out_op1, e.op1b);
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Present one instruction until accepted; expectation built at acceptance.
  // ctl = {invalid, mem_read, mem_write, wb_reg_file}
  task automatic issue(input logic [31:0] ins, input logic [31:0] ipc,
                       input logic r1u, input logic r2u,
                       input logic [31:0] eimm, input logic [3:0] ctl);
    exp_t x;
    bit ok;
    in_valid = 1'b1; instr = ins; pc = ipc;
    last_wait = 0; ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifa.in_ready) begin ok = 1; break; end
      last_wait++;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    x.pc   = ipc;
    x.op1  = r1u ? rdm(ins[19:15], 1'b1) : 32'd0;
    x.op1b = r1u ? rdm(ins[19:15], 1'b0) : 32'd0;
    x.op2  = r2u ? rdm(ins[24:20], 1'b1) : 32'd0;
    x.imm  = eimm;
    x.rd   = ins[11:7];
    x.opc  = ins[6:0];
    {x.inv, x.mr, x.mw, x.wb} = ctl;
    sb.push_back(x);
    n_iss++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_vld", ifa.out_valid, 1'b0);
    check("rst_pc", ifa.out_pc, 32'd0);
    check("rst_imm", ifa.out_imm, 32'd0);
    check("rst_inv", ifa.out_invalid, 1'b0);
    check("rst_cdec", cnt_dec_a, 16'd0);
    check("rst_cbub", cnt_bub_a, 16'd0);
    check("rst_rdy", ifa.in_ready, 1'b1);
    @(posedge clk); #1;

    // Basic ALU issue
    wb_write(5'd1, 32'h40);
    issue(enc_i(7'b0010011, 5'd1, 3'b000, 5'd0, 12'd5), 32'h100, 1, 0, 32'd5, 4'b0001);
    issue(enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd2), 32'h104, 1, 1, 32'd0, 4'b0001);
    idle(3);
    check("t1_cdec", cnt_dec_a, 16'd2);
    check("t1_cbub", cnt_bub_a, 16'd0);

    // Load-use
    issue(enc_i(7'b0000011, 5'd3, 3'b010, 5'd1, 12'd0), 32'h110, 1, 0, 32'd0, 4'b0101);
    issue(enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4), 32'h114, 1, 1, 32'd0, 4'b0001);
    check("t2_wait", last_wait, 1);
    issue(enc_i(7'b0000011, 5'd0, 3'b010, 5'd1, 12'd0), 32'h118, 1, 0, 32'd0, 4'b0101);
    issue(enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd5), 32'h11c, 1, 1, 32'd0, 4'b0001);
    check("t2_x0_wait", last_wait, 0);
    idle(2);
    check("t2_cbub", cnt_bub_a, 16'd1);

    // Immediate formats
    issue(enc_s(12'hffc, 5'd1, 5'd1, 3'b010), 32'h120, 1, 1, 32'hfffffffc, 4'b0010);
    issue(enc_b(13'h1ff8, 5'd2, 5'd1, 3'b000), 32'h124, 1, 1, 32'hfffffff8, 4'b0000);
    issue({20'h12345, 5'd11, 7'b0110111}, 32'h128, 0, 0, 32'h12345000, 4'b0001);
    issue(enc_j(21'h1ff800, 5'd1), 32'h12c, 0, 0, 32'hfffff800, 4'b0001);

    // Stall: entry must hold while EX is not ready
    issue(enc_i(7'b0010011, 5'd7, 3'b000, 5'd0, 12'd9), 32'h200, 1, 0, 32'd9, 4'b0001);
    ex_ready = 1'b0;
    in_valid = 1'b1; instr = enc_i(7'b0010011, 5'd8, 3'b000, 5'd1, 12'h7ff); pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_vld", ifa.out_valid, 1'b1);
      check("t3_pc", ifa.out_pc, 32'h200);
      check("t3_imm", ifa.out_imm, 32'd9);
      check("t3_rd", ifa.out_rd, 5'd7);
      check("t3_rdy", ifa.in_ready, 1'b0);
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    issue(enc_i(7'b0010011, 5'd8, 3'b000, 5'd1, 12'h7ff), 32'h204, 1, 0, 32'h7ff, 4'b0001);
    check("t3_nowait", last_wait, 0);
    idle(2);

    // Flush while stalled
    issue(enc_i(7'b0010011, 5'd9, 3'b000, 5'd0, 12'd1), 32'h300, 1, 0, 32'd1, 4'b0001);
    ex_ready = 1'b0; id_flush = 1'b1;
    in_valid = 1'b1; instr = enc_i(7'b0010011, 5'd10, 3'b000, 5'd0, 12'd2); pc = 32'h304;
    @(negedge clk);
    check("t4_rdy", ifa.in_ready, 1'b1);
    check("t4_vld_pre", ifa.out_valid, 1'b1);
    @(posedge clk); #1;
    id_flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    void'(sb.pop_back());
    n_iss--;
    @(negedge clk);
    check("t4_vld_post", ifa.out_valid, 1'b0);
    @(posedge clk); #1;

    // WB write-through vs. held value
    wb_write(5'd5, 32'h11111111);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hdeadbeef;
    issue(enc_r(7'd0, 5'd0, 5'd5, 3'b000, 5'd6), 32'h400, 1, 1, 32'd0, 4'b0001);
    wr_en = 1'b0;
    issue(enc_r(7'd0, 5'd0, 5'd5, 3'b000, 5'd12), 32'h404, 1, 1, 32'd0, 4'b0001);
    idle(1);
    check("t5_a_op1", dut_a.bus.out_op1, 32'hdeadbeef);
    check("t5_b_op1", dut_b.bus.out_op1, 32'hdeadbeef);

    // Illegal instruction
    issue(32'hffffffff, 32'h500, 1, 0, 32'd0, 4'b1000);
    idle(3);
    check("t6_cdec", cnt_dec_a, n_iss);
    check("t6_cdec_sat", cnt_dec_b, 2'd3);
    check("t6_cbub_b", cnt_bub_b, 2'd1);
    check("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
